// File: rtl/mag_sequencer_if.sv
// mag_sequencer_if: panel-side controls and latch-side outputs of the magnetron sequencer
interface mag_sequencer_if #(
  parameter int TW = 8
);
  logic          tick;
  logic          start;
  logic          stop;
  logic          door_closed;
  logic [1:0]    power_level;
  logic [TW-1:0] cook_time;
  logic          mag_set;
  logic          mag_reset;
  logic          mag_on;
  logic          busy;
  logic          done;
  logic [TW-1:0] remaining;
  modport master (
    output tick, start, stop, door_closed, power_level, cook_time,
    input  mag_set, mag_reset, mag_on, busy, done, remaining
  );
  modport slave (
    input  tick, start, stop, door_closed, power_level, cook_time,
    output mag_set, mag_reset, mag_on, busy, done, remaining
  );
endinterface

// File: rtl/mag_sequencer.sv
// mag_sequencer: magnetron latch sequencer with duty windows and cook timer; MAG_SOFTSTART_EN halves the first window after each start/resume
module mag_sequencer #(
  parameter int PERIOD = 10,
  parameter int TW     = 8
) (
  input logic            clk,
  input logic            rst_n,
  mag_sequencer_if.slave bus
);
  localparam int WW = $clog2(PERIOD + 1);
  typedef enum logic [2:0] {INIT, IDLE, HEAT, REST, PAUSE} state_t;
  state_t        r_state, w_nxt;
  logic [WW-1:0] r_win, w_win, w_win_inc, w_on, w_on_norm;
  logic [1:0]    r_pwr, w_pwr;
  logic [TW-1:0] r_rem, w_rem, w_rem_dec;
  logic          r_set, r_rst, r_on, r_busy, r_done;
  logic          w_set, w_rst, w_done, w_cook, w_halt, w_adv, w_load;
  assign w_cook    = r_state == HEAT || r_state == REST;
  assign w_halt    = !bus.door_closed || bus.stop;
  assign w_adv     = w_cook && !w_halt && bus.tick;
  assign w_rem_dec = r_rem - 1'b1;
  assign w_win_inc = r_win + 1'b1;
  assign w_on_norm = WW'((PERIOD * (int'(r_pwr) + 1)) / 4);
`ifdef MAG_SOFTSTART_EN
  logic r_first;
  assign w_on = (r_first && w_on_norm > WW'(1)) ? w_on_norm >> 1 : w_on_norm;
  // first window after a start/resume is the soft one; it ends on entering REST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_first <= 1'b0;
    else        r_first <= w_load || (r_first && w_nxt != REST);
  end
`else
  assign w_on = w_on_norm;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_nxt;
  end
  // next state: door/stop beat tick, completion beats window change
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      INIT:  w_nxt = IDLE;
      IDLE:  w_nxt = (bus.start && bus.door_closed && bus.cook_time != '0) ? HEAT : IDLE;
      HEAT:  w_nxt = w_halt ? PAUSE : !bus.tick ? HEAT : w_rem_dec == '0 ? IDLE :
                     (w_win_inc == w_on && w_on < WW'(PERIOD)) ? REST : HEAT;
      REST:  w_nxt = w_halt ? PAUSE : !bus.tick ? REST : w_rem_dec == '0 ? IDLE :
                     w_win_inc == WW'(PERIOD) ? HEAT : REST;
      PAUSE: w_nxt = bus.stop ? IDLE : (bus.start && bus.door_closed) ? HEAT : PAUSE;
      default: w_nxt = INIT;
    endcase
  end
  // pulses and datapath next values, derived from the transition taken
  always_comb begin
    w_load = (r_state == IDLE || r_state == PAUSE) && w_nxt == HEAT;
    w_set  = r_state != HEAT && w_nxt == HEAT;
    w_rst  = r_state == INIT || (r_state == HEAT && w_nxt != HEAT);
    w_done = w_cook && w_nxt == IDLE;
    w_pwr  = w_load ? bus.power_level : r_pwr;
    w_rem  = (r_state == IDLE && w_load) ? bus.cook_time :
             (r_state == PAUSE && w_nxt == IDLE) ? '0 : w_adv ? w_rem_dec : r_rem;
    w_win  = (w_nxt == PAUSE || w_set || (w_adv && w_win_inc == WW'(PERIOD))) ? '0 :
             w_adv ? w_win_inc : r_win;
  end
  // registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set  <= 1'b0;
      r_rst  <= 1'b0;
      r_on   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_rem  <= '0;
      r_win  <= '0;
      r_pwr  <= '0;
    end else begin
      r_set  <= w_set;
      r_rst  <= w_rst;
      r_on   <= w_nxt == HEAT;
      r_busy <= w_nxt inside {HEAT, REST, PAUSE};
      r_done <= w_done;
      r_rem  <= w_rem;
      r_win  <= w_win;
      r_pwr  <= w_pwr;
    end
  end
  assign bus.mag_set   = r_set;
  assign bus.mag_reset = r_rst;
  assign bus.mag_on    = r_on;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.remaining = r_rem;
endmodule

// File: tb/tb_mag_sequencer.sv
// tb_mag_sequencer: scenario bench with a pulse scoreboard for mag_sequencer
module tb_mag_sequencer;
  typedef struct packed {
    logic       s;
    logic       r;
    logic       d;
    logic       on;
    logic       busy;
    logic [7:0] rem;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  ev_t  exp_q[$];
  mag_sequencer_if #(.TW(8)) bus ();
  mag_sequencer #(.PERIOD(10), .TW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic ev_t mk(logic s, logic r, logic d, logic on, logic busy, logic [7:0] rem);
    return {s, r, d, on, busy, rem};
  endfunction
  // every pulse is popped against the next expected event
  always @(negedge clk) begin
    if (rst_n && (bus.mag_set || bus.mag_reset || bus.done)) begin
      ev_t o;
      o = {bus.mag_set, bus.mag_reset, bus.done, bus.mag_on, bus.busy, bus.remaining};
      n_total++;
      if (bus.mag_set && bus.mag_reset) $display("FAIL set_and_reset t=%0t got both high want exclusive", $time);
      else n_pass++;
      n_total++;
      if (exp_q.size() == 0) $display("FAIL unexpected_pulse t=%0t got %b want none", $time, o);
      else begin
        ev_t e;
        e = exp_q.pop_front();
        if (o !== e) $display("FAIL pulse_event t=%0t got %b want %b", $time, o, e);
        else n_pass++;
      end
    end
  end
  task automatic tick_once;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic pulse_start;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.mag_set, bus.mag_reset, bus.mag_on, bus.busy, bus.done} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {bus.mag_set, bus.mag_reset, bus.mag_on, bus.busy, bus.done});
    else n_pass++;
    n_total++;
    if (bus.remaining !== 8'd0) $display("FAIL reset_rem got %0d want 0", bus.remaining);
    else n_pass++;
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.mag_reset !== 1'b0 || bus.busy !== 1'b0) $display("FAIL init_after got rst=%b busy=%b want 0 0", bus.mag_reset, bus.busy);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL init_pulse got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask
  task automatic test_full_power;
    bus.power_level = 2'd3;
    bus.cook_time = 8'd5;
    exp_q.push_back(mk(1, 0, 0, 1, 1, 5));
    pulse_start();
    for (int i = 1; i <= 4; i++) begin
      tick_once();
      n_total++;
      if (bus.remaining !== 8'(5 - i) || bus.mag_on !== 1'b1) $display("FAIL full_tick%0d got rem=%0d on=%b want rem=%0d on=1", i, bus.remaining, bus.mag_on, 5 - i);
      else n_pass++;
    end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0));
    tick_once();
    n_total++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0) $display("FAIL full_end got busy=%b pending=%0d want 0 0", bus.busy, exp_q.size());
    else n_pass++;
  endtask
  task automatic test_duty_level0;
    logic exp_on;
    bus.power_level = 2'd0;
    bus.cook_time = 8'd25;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(1, 0, 0, 1, 1, 8'(25 - 10 * k)));
      exp_q.push_back(mk(0, 1, 0, 0, 1, 8'(23 - 10 * k)));
    end
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
    pulse_start();
    for (int i = 1; i <= 25; i++) begin
      tick_once();
      exp_on = (i < 25) && ((i % 10) < 2);
      n_total++;
      if (bus.remaining !== 8'(25 - i) || bus.mag_on !== exp_on) $display("FAIL duty_tick%0d got rem=%0d on=%b want rem=%0d on=%b", i, bus.remaining, bus.mag_on, 25 - i, exp_on);
      else n_pass++;
    end
    n_total++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0) $display("FAIL duty_end got busy=%b pending=%0d want 0 0", bus.busy, exp_q.size());
    else n_pass++;
  endtask
  task automatic test_door_open;
    bus.power_level = 2'd1;
    bus.cook_time = 8'd20;
    exp_q.push_back(mk(1, 0, 0, 1, 1, 20));
    pulse_start();
    repeat (3) tick_once();
    exp_q.push_back(mk(0, 1, 0, 0, 1, 17));
    bus.door_closed = 1'b0;
    @(negedge clk);
    repeat (2) tick_once();
    n_total++;
    if (bus.remaining !== 8'd17 || bus.busy !== 1'b1 || bus.mag_on !== 1'b0) $display("FAIL door_pause got rem=%0d busy=%b on=%b want 17 1 0", bus.remaining, bus.busy, bus.mag_on);
    else n_pass++;
    bus.door_closed = 1'b1;
    bus.power_level = 2'd3;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1 || bus.mag_on !== 1'b0) $display("FAIL door_closed_no_start got busy=%b on=%b want 1 0", bus.busy, bus.mag_on);
    else n_pass++;
    bus.power_level = 2'd1;
    exp_q.push_back(mk(1, 0, 0, 1, 1, 17));
    exp_q.push_back(mk(0, 1, 0, 0, 1, 12));
    exp_q.push_back(mk(1, 0, 0, 1, 1, 7));
    exp_q.push_back(mk(0, 1, 0, 0, 1, 2));
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
    pulse_start();
    repeat (17) tick_once();
    n_total++;
    if (bus.busy !== 1'b0 || bus.remaining !== 8'd0 || exp_q.size() != 0) $display("FAIL door_end got busy=%b rem=%0d pending=%0d want 0 0 0", bus.busy, bus.remaining, exp_q.size());
    else n_pass++;
  endtask
  task automatic test_cancel;
    bus.power_level = 2'd2;
    bus.cook_time = 8'd30;
    exp_q.push_back(mk(1, 0, 0, 1, 1, 30));
    pulse_start();
    repeat (2) tick_once();
    exp_q.push_back(mk(0, 1, 0, 0, 1, 28));
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1 || bus.remaining !== 8'd28) $display("FAIL cancel_pause got busy=%b rem=%0d want 1 28", bus.busy, bus.remaining);
    else n_pass++;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || bus.remaining !== 8'd0 || bus.mag_on !== 1'b0) $display("FAIL cancel_idle got busy=%b rem=%0d on=%b want 0 0 0", bus.busy, bus.remaining, bus.mag_on);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL cancel_pulses got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask
  task automatic test_same_cycle;
    bus.power_level = 2'd0;
    bus.cook_time = 8'd50;
    exp_q.push_back(mk(1, 0, 0, 1, 1, 50));
    exp_q.push_back(mk(0, 1, 0, 0, 1, 48));
    pulse_start();
    repeat (3) tick_once();
    bus.door_closed = 1'b0;
    tick_once();
    n_total++;
    if (bus.remaining !== 8'd47 || bus.busy !== 1'b1 || bus.mag_on !== 1'b0) $display("FAIL door_tick got rem=%0d busy=%b on=%b want 47 1 0", bus.remaining, bus.busy, bus.mag_on);
    else n_pass++;
    bus.door_closed = 1'b1;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || bus.remaining !== 8'd0) $display("FAIL rest_cancel got busy=%b rem=%0d want 0 0", bus.busy, bus.remaining);
    else n_pass++;
    bus.cook_time = 8'd0;
    pulse_start();
    bus.cook_time = 8'd5;
    bus.door_closed = 1'b0;
    pulse_start();
    bus.door_closed = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || bus.mag_on !== 1'b0 || exp_q.size() != 0) $display("FAIL ignored_start got busy=%b on=%b pending=%0d want 0 0 0", bus.busy, bus.mag_on, exp_q.size());
    else n_pass++;
  endtask
  task automatic test_reset_midcook;
    bus.power_level = 2'd3;
    bus.cook_time = 8'd10;
    exp_q.push_back(mk(1, 0, 0, 1, 1, 10));
    pulse_start();
    repeat (2) tick_once();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.mag_on, bus.busy, bus.mag_reset} !== 3'b0 || bus.remaining !== 8'd0) $display("FAIL midcook_reset got on=%b busy=%b rst=%b rem=%0d want 0 0 0 0", bus.mag_on, bus.busy, bus.mag_reset, bus.remaining);
    else n_pass++;
    @(negedge clk);
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) $display("FAIL midcook_init got pending=%0d busy=%b want 0 0", exp_q.size(), bus.busy);
    else n_pass++;
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.door_closed = 1'b1;
    bus.power_level = 2'd0;
    bus.cook_time = 8'd0;
    test_reset();
    test_full_power();
    test_duty_level0();
    test_door_open();
    test_cancel();
    test_same_cycle();
    test_reset_midcook();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
